// File: rtl/capture_rr_arbiter.sv
// Packet-granular two-queue AXI-Stream arbiter for the capture path.
// Round-robin or strict-q0 selection at packet boundaries; disabled queues are drained and counted as drops.
module capture_rr_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                            axi_aclk,
    input  logic                            axi_aresetn,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_0,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
    input  logic                            s_axis_tvalid_0,
    input  logic                            s_axis_tlast_0,
    output logic                            s_axis_tready_0,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_1,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
    input  logic                            s_axis_tvalid_1,
    input  logic                            s_axis_tlast_1,
    output logic                            s_axis_tready_1,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,

    input  logic [1:0]                      cfg_enable,
    input  logic                            cfg_prio0,

    output logic [C_CNT_WIDTH-1:0]          fwd_cnt_0,
    output logic [C_CNT_WIDTH-1:0]          fwd_cnt_1,
    output logic [C_CNT_WIDTH-1:0]          drop_cnt_0,
    output logic [C_CNT_WIDTH-1:0]          drop_cnt_1
);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t state, state_nxt;
    logic   grant, grant_nxt;
    logic   last_served, last_served_nxt;
    logic   sel;
    logic   grant_tvalid, grant_tlast;
    logic   grant_ready;
    logic   pkt_done;

    // State and arbitration history; the enable decision lives in PASS vs DROP.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_served <= 1'b1;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            last_served <= last_served_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        last_served_nxt = last_served;
        grant_ready     = 1'b0;
        pkt_done        = 1'b0;
        m_axis_tvalid   = 1'b0;

        if (s_axis_tvalid_0 && s_axis_tvalid_1) begin
            sel = cfg_prio0 ? 1'b0 : ~last_served;
        end else begin
            sel = s_axis_tvalid_1;
        end

        grant_tvalid  = grant ? s_axis_tvalid_1 : s_axis_tvalid_0;
        grant_tlast   = grant ? s_axis_tlast_1  : s_axis_tlast_0;
        m_axis_tdata  = grant ? s_axis_tdata_1  : s_axis_tdata_0;
        m_axis_tstrb  = grant ? s_axis_tstrb_1  : s_axis_tstrb_0;
        m_axis_tuser  = grant ? s_axis_tuser_1  : s_axis_tuser_0;
        m_axis_tlast  = grant_tlast;

        case (state)
            IDLE: begin
                if (s_axis_tvalid_0 || s_axis_tvalid_1) begin
                    grant_nxt = sel;
                    state_nxt = cfg_enable[sel] ? PASS : DROP;
                end
            end
            PASS: begin
                m_axis_tvalid = grant_tvalid;
                grant_ready   = m_axis_tready;
                pkt_done      = grant_tvalid && m_axis_tready && grant_tlast;
            end
            DROP: begin
                grant_ready = 1'b1;
                pkt_done    = grant_tvalid && grant_tlast;
            end
            default: state_nxt = IDLE;
        endcase

        if (pkt_done) begin
            last_served_nxt = grant;
            state_nxt       = IDLE;
        end

        s_axis_tready_0 = grant_ready && !grant;
        s_axis_tready_1 = grant_ready &&  grant;
    end

    // Counters bump on the tlast beat and wrap naturally.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            fwd_cnt_0  <= '0;
            fwd_cnt_1  <= '0;
            drop_cnt_0 <= '0;
            drop_cnt_1 <= '0;
        end else if (pkt_done) begin
            if (state == PASS) begin
                if (grant) fwd_cnt_1 <= fwd_cnt_1 + CNT_ONE;
                else       fwd_cnt_0 <= fwd_cnt_0 + CNT_ONE;
            end else begin
                if (grant) drop_cnt_1 <= drop_cnt_1 + CNT_ONE;
                else       drop_cnt_0 <= drop_cnt_0 + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_capture_rr_arbiter.sv
// Bench for capture_rr_arbiter: table-driven arbitration cases, directed corner sequences
// and randomized traffic scored against a packet-level model of the two queues.
module tb_capture_rr_arbiter;

    localparam int DW = 32;
    localparam int UW = 8;
    localparam int CW = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [1:0] en;
        logic       prio;
        int         n0;
        int         n1;
        int         exp_len;
        logic [7:0] order;
        int         fwd0;
        int         fwd1;
        int         drop0;
        int         drop1;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   s_tdata_0, s_tdata_1, m_tdata;
    logic [DW/8-1:0] s_tstrb_0, s_tstrb_1, m_tstrb;
    logic [UW-1:0]   s_tuser_0, s_tuser_1, m_tuser;
    logic            s_tvalid_0, s_tvalid_1, s_tlast_0, s_tlast_1;
    logic            s_tready_0, s_tready_1;
    logic            m_tvalid, m_tlast, m_tready;
    logic [1:0]      cfg_enable;
    logic            cfg_prio0;
    logic [CW-1:0]   fwd_cnt_0, fwd_cnt_1, drop_cnt_0, drop_cnt_1;

    always #5 clk = ~clk;

    capture_rr_arbiter #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .C_CNT_WIDTH       (CW)
    ) dut (
        .axi_aclk        (clk),
        .axi_aresetn     (rst_n),
        .s_axis_tdata_0  (s_tdata_0),
        .s_axis_tstrb_0  (s_tstrb_0),
        .s_axis_tuser_0  (s_tuser_0),
        .s_axis_tvalid_0 (s_tvalid_0),
        .s_axis_tlast_0  (s_tlast_0),
        .s_axis_tready_0 (s_tready_0),
        .s_axis_tdata_1  (s_tdata_1),
        .s_axis_tstrb_1  (s_tstrb_1),
        .s_axis_tuser_1  (s_tuser_1),
        .s_axis_tvalid_1 (s_tvalid_1),
        .s_axis_tlast_1  (s_tlast_1),
        .s_axis_tready_1 (s_tready_1),
        .m_axis_tdata    (m_tdata),
        .m_axis_tstrb    (m_tstrb),
        .m_axis_tuser    (m_tuser),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tlast    (m_tlast),
        .m_axis_tready   (m_tready),
        .cfg_enable      (cfg_enable),
        .cfg_prio0       (cfg_prio0),
        .fwd_cnt_0       (fwd_cnt_0),
        .fwd_cnt_1       (fwd_cnt_1),
        .drop_cnt_0      (drop_cnt_0),
        .drop_cnt_1      (drop_cnt_1)
    );

    int    checks = 0;
    int    failures = 0;
    beat_t src0[$], src1[$], exp0[$], exp1[$];
    logic  pres0, pres1;
    int    seq0, seq1;
    int    mdl_fwd0, mdl_fwd1, mdl_drop0, mdl_drop1;
    int    step_no, out_beats, ready1_cnt, mvalid_cnt;
    int    beat_steps[$];
    int    out_order[$];
    logic  in_pkt, cur_q;
    int    hole_pct, tready_mode;
    logic  hook_clear_en0;
    vec_t  vecs[7];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input int q, input int len, input logic fwd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data[31]    = q[0];
            b.data[30:16] = (q == 0) ? seq0[14:0] : seq1[14:0];
            b.data[15:8]  = i[7:0];
            b.data[7:0]   = 8'($urandom);
            b.last        = (i == len - 1);
            if (q == 0) src0.push_back(b); else src1.push_back(b);
            if (fwd) begin
                if (q == 0) exp0.push_back(b); else exp1.push_back(b);
            end
        end
        if (q == 0) seq0++; else seq1++;
        if (q == 0 && fwd)  mdl_fwd0++;
        if (q == 1 && fwd)  mdl_fwd1++;
        if (q == 0 && !fwd) mdl_drop0++;
        if (q == 1 && !fwd) mdl_drop1++;
    endtask

    // Score one accepted output beat against the per-queue expectation.
    task automatic score_beat();
        beat_t e;
        logic  q;
        q = m_tdata[31];
        checks++;
        if ((q == 1'b0 && exp0.size() == 0) || (q == 1'b1 && exp1.size() == 0)) begin
            failures++;
            $display("[TB] FAIL unexpected_beat actual=%0h expected=none", m_tdata);
        end else begin
            e = (q == 1'b0) ? exp0.pop_front() : exp1.pop_front();
            if (m_tdata !== e.data || m_tlast !== e.last ||
                m_tuser !== (e.data[7:0] ^ 8'hA5) || m_tstrb !== e.data[3:0]) begin
                failures++;
                $display("[TB] FAIL beat actual=%0h/%0b expected=%0h/%0b", m_tdata, m_tlast, e.data, e.last);
            end
        end
        if (in_pkt) check_output("pkt_interleave", 32'(q), 32'(cur_q));
        in_pkt = !m_tlast;
        cur_q  = q;
        out_beats++;
        beat_steps.push_back(step_no);
        if (m_tlast) out_order.push_back(int'(q));
    endtask

    // One clock of stimulus: drive at negedge, observe handshakes 1 ns later.
    task automatic apply_stimulus();
        @(negedge clk);
        step_no++;
        if (!pres0 && src0.size() > 0 && $urandom_range(0, 99) >= hole_pct) pres0 = 1'b1;
        if (!pres1 && src1.size() > 0 && $urandom_range(0, 99) >= hole_pct) pres1 = 1'b1;
        s_tvalid_0 = pres0;
        s_tdata_0  = pres0 ? src0[0].data : '0;
        s_tlast_0  = pres0 ? src0[0].last : 1'b0;
        s_tuser_0  = s_tdata_0[7:0] ^ 8'hA5;
        s_tstrb_0  = s_tdata_0[3:0];
        s_tvalid_1 = pres1;
        s_tdata_1  = pres1 ? src1[0].data : '0;
        s_tlast_1  = pres1 ? src1[0].last : 1'b0;
        s_tuser_1  = s_tdata_1[7:0] ^ 8'hA5;
        s_tstrb_1  = s_tdata_1[3:0];
        case (tready_mode)
            1:       m_tready = 1'($urandom);
            2:       m_tready = step_no[0];
            default: m_tready = 1'b1;
        endcase
        #1;
        if (s_tvalid_0 && s_tready_0) begin
            void'(src0.pop_front());
            pres0 = 1'b0;
        end
        if (s_tvalid_1 && s_tready_1) begin
            void'(src1.pop_front());
            pres1 = 1'b0;
        end
        if (s_tready_1) ready1_cnt++;
        if (m_tvalid)   mvalid_cnt++;
        if (m_tvalid && m_tready) score_beat();
        if (hook_clear_en0 && out_beats == 2) begin
            cfg_enable     = 2'b10;
            hook_clear_en0 = 1'b0;
        end
    endtask

    task automatic run_drain(input int budget);
        int n = 0;
        while ((src0.size() + src1.size() + exp0.size() + exp1.size()) > 0 && n < budget) begin
            apply_stimulus();
            n++;
        end
        if ((src0.size() + src1.size() + exp0.size() + exp1.size()) > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d_left expected=0",
                     src0.size() + src1.size() + exp0.size() + exp1.size());
            src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
            pres0 = 1'b0;
            pres1 = 1'b0;
        end
        apply_stimulus();
        apply_stimulus();
    endtask

    task automatic clear_model();
        src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
        pres0 = 1'b0; pres1 = 1'b0;
        s_tvalid_0 = 1'b0; s_tvalid_1 = 1'b0;
        s_tlast_0 = 1'b0;  s_tlast_1 = 1'b0;
        mdl_fwd0 = 0; mdl_fwd1 = 0; mdl_drop0 = 0; mdl_drop1 = 0;
        in_pkt = 1'b0;
        out_beats = 0; step_no = 0; ready1_cnt = 0; mvalid_cnt = 0;
        beat_steps.delete();
        out_order.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step_no = 0;
    endtask

    task automatic check_counters(input string tag);
        check_output({tag, "_fwd0"},  32'(fwd_cnt_0),  32'(mdl_fwd0  % 16));
        check_output({tag, "_fwd1"},  32'(fwd_cnt_1),  32'(mdl_fwd1  % 16));
        check_output({tag, "_drop0"}, 32'(drop_cnt_0), 32'(mdl_drop0 % 16));
        check_output({tag, "_drop1"}, 32'(drop_cnt_1), 32'(mdl_drop1 % 16));
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_enable = 2'b11; cfg_prio0 = 1'b0; m_tready = 1'b1;
        s_tdata_0 = '0; s_tdata_1 = '0; s_tstrb_0 = '0; s_tstrb_1 = '0;
        s_tuser_0 = '0; s_tuser_1 = '0;
        hole_pct = 0; tready_mode = 0; hook_clear_en0 = 1'b0;
        seq0 = 0; seq1 = 0;
        clear_model();

        //            en     prio n0 n1 len order        f0 f1 d0 d1
        vecs[0] = '{2'b11, 1'b0, 4, 4, 8, 8'b10101010, 4, 4, 0, 0};
        vecs[1] = '{2'b11, 1'b1, 4, 4, 8, 8'b11110000, 4, 4, 0, 0};
        vecs[2] = '{2'b01, 1'b0, 2, 2, 2, 8'b00000000, 2, 0, 0, 2};
        vecs[3] = '{2'b10, 1'b0, 3, 1, 1, 8'b00000001, 0, 1, 3, 0};
        vecs[4] = '{2'b11, 1'b0, 0, 3, 3, 8'b00000111, 0, 3, 0, 0};
        vecs[5] = '{2'b00, 1'b0, 2, 2, 0, 8'b00000000, 0, 0, 2, 2};
        vecs[6] = '{2'b11, 1'b1, 1, 3, 4, 8'b00001110, 1, 3, 0, 0};

        do_reset();
        #1;
        check_output("reset_m_tvalid", 32'(m_tvalid), 0);
        check_output("reset_tready0", 32'(s_tready_0), 0);
        check_output("reset_tready1", 32'(s_tready_1), 0);
        check_counters("reset");

        // Arbitration order table, single-beat packets queued on both inputs.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            cfg_enable = vecs[v].en;
            cfg_prio0  = vecs[v].prio;
            for (int i = 0; i < vecs[v].n0; i++) push_pkt(0, 1, vecs[v].en[0]);
            for (int i = 0; i < vecs[v].n1; i++) push_pkt(1, 1, vecs[v].en[1]);
            run_drain(200);
            check_output($sformatf("vec%0d_len", v), 32'(out_order.size()), 32'(vecs[v].exp_len));
            for (int i = 0; i < out_order.size() && i < vecs[v].exp_len; i++)
                check_output($sformatf("vec%0d_order%0d", v, i), 32'(out_order[i]), 32'(vecs[v].order[i]));
            check_output($sformatf("vec%0d_fwd0", v),  32'(fwd_cnt_0),  32'(vecs[v].fwd0));
            check_output($sformatf("vec%0d_fwd1", v),  32'(fwd_cnt_1),  32'(vecs[v].fwd1));
            check_output($sformatf("vec%0d_drop0", v), 32'(drop_cnt_0), 32'(vecs[v].drop0));
            check_output($sformatf("vec%0d_drop1", v), 32'(drop_cnt_1), 32'(vecs[v].drop1));
        end

        // Zero-latency pass-through: one IDLE cycle, then beats on cycles 2..4.
        do_reset();
        cfg_enable = 2'b11; cfg_prio0 = 1'b0;
        push_pkt(0, 3, 1'b1);
        run_drain(50);
        check_output("latency_beats", 32'(beat_steps.size()), 3);
        for (int i = 0; i < beat_steps.size() && i < 3; i++)
            check_output($sformatf("latency_step%0d", i), 32'(beat_steps[i]), 32'(i + 2));
        check_output("latency_fwd0", 32'(fwd_cnt_0), 1);

        // Disabled queue drained: ready high for every drop beat, nothing forwarded.
        do_reset();
        cfg_enable = 2'b01;
        push_pkt(1, 5, 1'b0);
        push_pkt(1, 5, 1'b0);
        run_drain(100);
        check_output("drop_ready1_cycles", 32'(ready1_cnt), 10);
        check_output("drop_mvalid_cycles", 32'(mvalid_cnt), 0);
        check_output("drop_cnt1", 32'(drop_cnt_1), 2);
        check_output("drop_fwd1", 32'(fwd_cnt_1), 0);

        // Enable cleared mid-packet: current packet completes, next one dropped.
        do_reset();
        cfg_enable = 2'b11;
        push_pkt(0, 4, 1'b1);
        push_pkt(0, 4, 1'b0);
        hook_clear_en0 = 1'b1;
        run_drain(100);
        check_output("midpkt_beats", 32'(out_beats), 4);
        check_output("midpkt_fwd0", 32'(fwd_cnt_0), 1);
        check_output("midpkt_drop0", 32'(drop_cnt_0), 1);

        // Toggling backpressure, then counter wrap at 2^CW.
        do_reset();
        cfg_enable = 2'b11;
        tready_mode = 2;
        push_pkt(0, 6, 1'b1);
        run_drain(100);
        check_output("bp_beats", 32'(out_beats), 6);
        check_output("bp_fwd0", 32'(fwd_cnt_0), 1);
        tready_mode = 0;
        for (int i = 0; i < 14; i++) push_pkt(0, 1, 1'b1);
        run_drain(200);
        check_output("wrap_pre", 32'(fwd_cnt_0), 15);
        push_pkt(0, 1, 1'b1);
        run_drain(50);
        check_output("wrap_zero", 32'(fwd_cnt_0), 0);

        // Reset in the middle of a packet, then first tie goes to q0.
        do_reset();
        cfg_enable = 2'b11;
        push_pkt(0, 1, 1'b1);
        run_drain(50);
        check_output("rstmid_pre_fwd0", 32'(fwd_cnt_0), 1);
        out_beats = 0;
        push_pkt(1, 4, 1'b1);
        for (int n = 0; n < 50 && out_beats < 2; n++) apply_stimulus();
        check_output("rstmid_beats_before", 32'(out_beats), 2);
        rst_n = 1'b0;
        #1;
        check_output("rstmid_m_tvalid", 32'(m_tvalid), 0);
        check_output("rstmid_tready0", 32'(s_tready_0), 0);
        check_output("rstmid_tready1", 32'(s_tready_1), 0);
        check_output("rstmid_fwd0", 32'(fwd_cnt_0), 0);
        check_output("rstmid_fwd1", 32'(fwd_cnt_1), 0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        push_pkt(1, 1, 1'b1);
        push_pkt(0, 1, 1'b1);
        run_drain(50);
        check_output("rstmid_order_len", 32'(out_order.size()), 2);
        if (out_order.size() > 0) check_output("rstmid_first_q0", 32'(out_order[0]), 0);

        // Randomized traffic against the packet-level queue model.
        do_reset();
        tready_mode = 1;
        for (int r = 0; r < 12; r++) begin
            cfg_enable = 2'($urandom);
            cfg_prio0  = 1'($urandom);
            hole_pct   = int'($urandom_range(0, 50));
            for (int q = 0; q < 2; q++)
                for (int p = int'($urandom_range(0, 4)); p > 0; p--)
                    push_pkt(q, int'($urandom_range(1, 5)), cfg_enable[q]);
            run_drain(2000);
            check_counters($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
